// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-port (instruction / data) block arbiter for main memory,
//               alternating priority on conflict.
// Revision    : 1.0
// ============================================================================
module mem_arbiter (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         I_READ,
    input  logic [27:0]  I_ADDR,
    output logic [127:0] I_READDATA,
    output logic         I_BUSYWAIT,
    input  logic         D_READ,
    input  logic         D_WRITE,
    input  logic [27:0]  D_ADDR,
    input  logic [127:0] D_WRITEDATA,
    output logic [127:0] D_READDATA,
    output logic         D_BUSYWAIT,
    output logic         M_READ,
    output logic         M_WRITE,
    output logic [27:0]  M_ADDR,
    output logic [127:0] M_WRITEDATA,
    input  logic [127:0] M_READDATA,
    input  logic         M_BUSYWAIT
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT_I   = 3'd1,
        S_GRANT_D   = 3'd2,
        S_RELEASE_I = 3'd3,
        S_RELEASE_D = 3'd4
    } state_t;

    state_t         r_state;
    logic           r_last_grant_d;
    logic           r_d_write;
    logic [127:0]   r_i_readdata;
    logic [127:0]   r_d_readdata;

    logic           w_i_pend;
    logic           w_d_pend;
    logic           w_grant_i;
    logic           w_grant_d;

    assign w_i_pend  = I_READ;
    assign w_d_pend  = D_READ | D_WRITE;

    // Strobes are gated by RESET so an in-flight transfer is dropped at once.
    assign w_grant_i = (r_state == S_GRANT_I) & ~RESET;
    assign w_grant_d = (r_state == S_GRANT_D) & ~RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= S_IDLE;
            r_last_grant_d <= 1'b0;
            r_d_write      <= 1'b0;
            r_i_readdata   <= '0;
            r_d_readdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_i_pend && (!w_d_pend || r_last_grant_d)) begin
                        r_state        <= S_GRANT_I;
                        r_last_grant_d <= 1'b0;
                    end else if (w_d_pend) begin
                        r_state        <= S_GRANT_D;
                        r_last_grant_d <= 1'b1;
                        // Operation is latched so a dropped request still completes.
                        r_d_write      <= D_WRITE;
                    end
                end
                S_GRANT_I: begin
                    if (!M_BUSYWAIT) begin
                        r_i_readdata <= M_READDATA;
                        r_state      <= S_RELEASE_I;
                    end
                end
                S_GRANT_D: begin
                    if (!M_BUSYWAIT) begin
                        if (!r_d_write) begin
                            r_d_readdata <= M_READDATA;
                        end
                        r_state <= S_RELEASE_D;
                    end
                end
                S_RELEASE_I,
                S_RELEASE_D: r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    assign I_READDATA  = r_i_readdata;
    assign D_READDATA  = r_d_readdata;

    assign I_BUSYWAIT  = w_i_pend & (r_state != S_RELEASE_I);
    assign D_BUSYWAIT  = w_d_pend & (r_state != S_RELEASE_D);

    assign M_READ      = w_grant_i | (w_grant_d & ~r_d_write);
    assign M_WRITE     = w_grant_d & r_d_write;
    assign M_ADDR      = w_grant_i ? I_ADDR : (w_grant_d ? D_ADDR : 28'd0);
    assign M_WRITEDATA = w_grant_d ? D_WRITEDATA : 128'd0;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 I_READ  input  1  instruction-port block read request (level, held until I_BUSYWAIT low).
REQ-004 I_ADDR  input  28  instruction-port block address.
REQ-005 I_READDATA  output  128  registered block returned to instruction port.
REQ-006 I_BUSYWAIT  output  1  instruction-port stall.
REQ-007 D_READ  input  1  data-port block read request (level).
REQ-008 D_WRITE  input  1  data-port block write request (level).
REQ-009 D_ADDR  input  28  data-port block address.
REQ-010 D_WRITEDATA  input  128  data-port write block.
REQ-011 D_READDATA  output  128  registered block returned to data port.
REQ-012 D_BUSYWAIT  output  1  data-port stall.
REQ-013 M_READ  output  1  main-memory read strobe.
REQ-014 M_WRITE  output  1  main-memory write strobe.
REQ-015 M_ADDR  output  28  main-memory block address.
REQ-016 M_WRITEDATA  output  128  main-memory write block.
REQ-017 M_READDATA  input  128  main-memory read block, valid when M_BUSYWAIT falls.
REQ-018 M_BUSYWAIT  input  1  main-memory busy; raised in the cycle M_READ/M_WRITE rises, held until transfer done.

Function
REQ-019 State machine SHALL have exactly five states: IDLE, GRANT_I, GRANT_D, RELEASE_I, RELEASE_D.
REQ-020 IDLE: pending = I_READ for I port; D_READ|D_WRITE for D port; none pending -> stay IDLE.
REQ-021 IDLE, only one port pending -> GRANT of that port next edge.
REQ-022 IDLE, both pending -> grant port NOT served last (LAST_GRANT flag); after reset, D port wins first conflict.
REQ-023 LAST_GRANT SHALL update on entry to GRANT_x to identify x.
REQ-024 In GRANT_I: M_READ=1, M_WRITE=0, M_ADDR=I_ADDR.
REQ-025 In GRANT_D: M_WRITE=D_WRITE, M_READ=D_READ&~D_WRITE (write wins if both high), M_ADDR=D_ADDR, M_WRITEDATA=D_WRITEDATA.
REQ-026 Outside GRANT states M_READ=M_WRITE=0; M_ADDR and M_WRITEDATA SHALL be 0.
REQ-027 Grant SHALL last at least one full cycle; completion = rising edge in GRANT_x (not the entry edge) with M_BUSYWAIT=0.
REQ-028 On completion of a read, M_READDATA SHALL be captured into I_READDATA or D_READDATA (granted port only); state -> RELEASE_x.
REQ-029 On completion of a write, read-data registers SHALL be unchanged; state -> RELEASE_D.
REQ-030 RELEASE_x lasts exactly one cycle, strobes low, then -> IDLE; a pending request SHALL re-arbitrate only from IDLE.
REQ-031 x_BUSYWAIT SHALL be combinational: 1 when port x pending and state != RELEASE_x; else 0.
REQ-032 Non-granted pending port SHALL see BUSYWAIT=1 for whole wait, no memory strobes on its behalf.
REQ-033 Requester dropping request mid-grant: grant SHALL be held until memory completion; read data still captured; then RELEASE_x, IDLE.
REQ-034 Address/data changes from granted requester mid-grant pass straight through; requester SHALL hold them stable (protocol rule, not checked).
REQ-035 Minimum turnaround: request at edge N -> GRANT at N+1 -> earliest completion N+2 -> RELEASE to N+3.
REQ-036 Throughput under continuous contention: strict alternation D, I, D, I.

Reset
REQ-037 RESET=1 at any rising edge SHALL force IDLE, LAST_GRANT=I (so D wins first), I_READDATA=D_READDATA=0, regardless of state.
REQ-038 During and after reset, M_READ=M_WRITE=0 and M_ADDR=M_WRITEDATA=0; in-flight memory transfer abandoned, no data captured.
REQ-039 BUSYWAIT outputs follow REQ-031 combinationally even while RESET=1.

Verification
REQ-040 I_READ=1, I_ADDR=0x0000010, memory 3-cycle latency returns 0xA5..A5 -> M_READ=1 M_ADDR=0x0000010 for 3 cycles, I_READDATA=0xA5..A5, I_BUSYWAIT low in RELEASE_I.
REQ-041 D_WRITE=1, D_ADDR=0x0000020, D_WRITEDATA=0x1234..; -> M_WRITE=1 with those values, D_READDATA unchanged (0), D_BUSYWAIT low after completion.
REQ-042 After reset, I_READ and D_READ high at same edge -> D granted first, I_BUSYWAIT=1 throughout; I granted right after RELEASE_D->IDLE.
REQ-043 Both ports continuously requesting 4 transfers -> grant order D, I, D, I; no cycle with both M_READ and M_WRITE high.
REQ-044 RESET pulsed mid GRANT_D read -> next cycle IDLE, M strobes 0, D_READDATA=0; request still high re-granted after reset released.
REQ-045 D_READ dropped one cycle into GRANT_D -> M_READ held until M_BUSYWAIT=0, D_READDATA captured, then IDLE; no spurious regrant.
